booth_seq_mul: RTL and testbench

//  Iterative radix-4 Booth multiplier, parametrised successor to the combinational 32x32 Booth unit.

---
 rtl/booth_pkg.sv | 30 +++
 rtl/booth_r4_digit.sv | 33 +++
 rtl/booth_seq_mul.sv | 109 ++++++++++
 tb/tb_booth_seq_mul.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// recoded digit codes and the window-to-digit recoding function.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] ZERO = 3'd0;
  localparam logic [2:0] P1   = 3'd1;
  localparam logic [2:0] P2   = 3'd2;
  localparam logic [2:0] M1   = 3'd3;
  localparam logic [2:0] M2   = 3'd4;

  // Window is {b[2k+1], b[2k], b[2k-1]}.
  function automatic logic [2:0] booth_recode(input logic [2:0] window);
    logic [2:0] code;
    case (window)
      3'b001, 3'b010: code = P1;
      3'b011:         code = P2;
      3'b100:         code = M2;
      3'b101, 3'b110: code = M1;
      default:        code = ZERO;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Combinational radix-4 Booth partial-product generator: maps one 3-bit
// multiplier window onto 0, +-a_x or +-2a_x as a (WIDTH+3)-bit signed value.
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       window,
  input  logic [WIDTH+1:0] a_x,
  output logic [WIDTH+2:0] pp
);

  logic [WIDTH+2:0] a_s;
  logic [WIDTH+2:0] a_s2;
  logic [2:0]       code;

  // One extra sign bit keeps +-2a_x representable for unsigned operands too.
  assign a_s  = {a_x[WIDTH+1], a_x};
  assign a_s2 = {a_s[WIDTH+1:0], 1'b0};
  assign code = booth_recode(window);

  always_comb begin
    pp = '0;
    case (code)
      P1:      pp = a_s;
      P2:      pp = a_s2;
      M1:      pp = -a_s;
      M2:      pp = -a_s2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_mul.sv
// Iterative radix-4 Booth multiplier: one recoded digit per clock through a
// single adder, signed/unsigned mode, start/busy/done handshake.
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int DIGITS = WIDTH / 2 + 1;
  localparam int ACC_W  = 2 * WIDTH + 4;
  localparam int CNT_W  = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  state_t               state_reg;
  logic [CNT_W-1:0]     counter_reg;
  logic [WIDTH+1:0]     a_x_reg;
  logic [WIDTH+2:0]     b_sh_reg;
  logic [ACC_W-1:0]     acc_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic [2*WIDTH-1:0]   product_reg;

  logic                 ext_a;
  logic                 ext_b;
  logic [WIDTH+2:0]     pp;
  logic [ACC_W-1:0]     pp_ext;
  logic [ACC_W-1:0]     pp_shifted;
  logic [ACC_W-1:0]     sum;
  logic [CNT_W:0]       shamt;

  assign ext_a = is_signed & a[WIDTH-1];
  assign ext_b = is_signed & b[WIDTH-1];

  // The multiplier is kept as a shift register so the current window is
  // always its three low bits; b_x[-1] = 0 enters as the LSB at capture.
  booth_r4_digit #(
    .WIDTH (WIDTH)
  ) u_digit (
    .window (b_sh_reg[2:0]),
    .a_x    (a_x_reg),
    .pp     (pp)
  );

  assign pp_ext     = {{(ACC_W - (WIDTH + 3)){pp[WIDTH+2]}}, pp};
  assign shamt      = {counter_reg, 1'b0};
  assign pp_shifted = pp_ext << shamt;
  assign sum        = acc_reg + pp_shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      a_x_reg     <= '0;
      b_sh_reg    <= '0;
      acc_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_x_reg     <= {ext_a, ext_a, a};
            b_sh_reg    <= {ext_b, ext_b, b, 1'b0};
            counter_reg <= '0;
            acc_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= RUN;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        RUN: begin
          acc_reg     <= sum;
          b_sh_reg    <= {2'b00, b_sh_reg[WIDTH+2:2]};
          counter_reg <= counter_reg + 1'b1;
          if (counter_reg == LAST_DIGIT) begin
            product_reg <= sum[2*WIDTH-1:0];
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = product_reg;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Randomized self-checking bench for booth_seq_mul (WIDTH=32 and WIDTH=8
// instances) against a plain-arithmetic reference multiply.
module tb_booth_seq_mul;

  logic        clk = 1'b0;
  logic        reset;

  logic        start32, sgn32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [63:0] prod32;

  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_seq_mul #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .product(prod32)
  );

  booth_seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  function automatic logic [63:0] ref32(input bit s, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = s ? longint'($signed(x)) : longint'({32'b0, x});
    sy = s ? longint'($signed(y)) : longint'({32'b0, y});
    return 64'(sx * sy);
  endfunction

  function automatic logic [15:0] ref8(input bit s, input logic [7:0] x, input logic [7:0] y);
    int sx, sy;
    sx = s ? int'($signed(x)) : int'({24'b0, x});
    sy = s ? int'($signed(y)) : int'({24'b0, y});
    return 16'(sx * sy);
  endfunction

  // Issues one operation from IDLE/DONE; lat = edges from the accepting edge
  // until done is seen (-1 on timeout).
  task automatic run32(input bit s, input logic [31:0] x, input logic [31:0] y,
                       output logic [63:0] p, output int lat);
    sgn32 = s; a32 = x; b32 = y; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done32 && busy32) begin
        checks++; errors++;
        $display("FAIL busy_done_overlap32 busy=%0b done=%0b required not both high", busy32, done32);
      end
      if (done32) begin lat = n; break; end
    end
    p = prod32;
  endtask

  task automatic run8(input bit s, input logic [7:0] x, input logic [7:0] y,
                      output logic [15:0] p, output int lat);
    sgn8 = s; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done8) begin lat = n; break; end
    end
    p = prod8;
  endtask

  task automatic check_op32(input string name, input bit s, input logic [31:0] x,
                            input logic [31:0] y);
    logic [63:0] p, exp;
    int lat;
    exp = ref32(s, x, y);
    run32(s, x, y, p, lat);
    checks++;
    if (p !== exp) begin
      errors++;
      $display("FAIL %s product s=%0b a=%h b=%h got=%h required=%h", name, s, x, y, p, exp);
    end
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL %s latency got=%0d required=17", name, lat);
    end
    $display("op32 %s s=%0b a=%h b=%h product=%h lat=%0d", name, s, x, y, p, lat);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start32 = 0; sgn32 = 0; a32 = '0; b32 = '0;
    start8 = 0; sgn8 = 0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy32, done32, prod32} !== 66'd0) begin
      errors++;
      $display("FAIL reset32 busy=%0b done=%0b product=%h required all zero", busy32, done32, prod32);
    end
    checks++;
    if ({busy8, done8, prod8} !== 18'd0) begin
      errors++;
      $display("FAIL reset8 busy=%0b done=%0b product=%h required all zero", busy8, done8, prod8);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%0b done=%0b required 0 0", busy32, done32);
    end
    $display("reset checked");
  endtask

  task automatic test_corners;
    check_op32("signed_m7x3", 1'b1, 32'hFFFF_FFF9, 32'd3);
    check_op32("unsigned_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op32("signed_min", 1'b1, 32'h8000_0000, 32'h8000_0000);
    check_op32("signed_m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op32("unsigned_min", 1'b0, 32'h8000_0000, 32'h8000_0000);
    check_op32("zero", 1'b1, 32'd0, 32'h1234_5678);
    // Fixed golden values cross-check the reference model itself.
    checks++;
    if (prod32 !== 64'd0) begin
      errors++;
      $display("FAIL zero_golden got=%h required=0", prod32);
    end
  endtask

  task automatic test_random32;
    for (int i = 0; i < 40; i++)
      check_op32("rand", 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    int t1 = -1, t2 = -1;
    logic [63:0] p1, p2;
    sgn32 = 1'b1; a32 = 32'd5; b32 = 32'd6; start32 = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done32 && busy32) begin
        checks++; errors++;
        $display("FAIL b2b_overlap cycle=%0d busy and done both high", i);
      end
      if (done32) begin
        ndone++;
        if (ndone == 1) begin t1 = i; p1 = prod32; end
        if (ndone == 2) begin t2 = i; p2 = prod32; end
      end
      if (i == 1) begin a32 = 32'hFFFF_FFFE; b32 = 32'hFFFF_FFFE; end
      if (t1 > 0 && i == t1 + 1) begin start32 = 1'b0; a32 = 32'd99; b32 = 32'd77; sgn32 = 1'b0; end
      if (t1 > 0 && i == t1 + 6) start32 = 1'b1;
      if (t1 > 0 && i == t1 + 7) start32 = 1'b0;
    end
    checks++;
    if (ndone !== 2) begin
      errors++;
      $display("FAIL b2b_count got=%0d required=2", ndone);
    end
    checks++;
    if (p1 !== 64'd30) begin
      errors++;
      $display("FAIL b2b_first got=%h required=%h", p1, 64'd30);
    end
    checks++;
    if (p2 !== 64'd4) begin
      errors++;
      $display("FAIL b2b_second got=%h required=%h", p2, 64'd4);
    end
    checks++;
    if (t2 - t1 !== 18) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d required=18", t2 - t1);
    end
    $display("b2b done_count=%0d p1=%h p2=%h spacing=%0d", ndone, p1, p2, t2 - t1);
  endtask

  task automatic test_reset_midrun;
    int seen = 0;
    sgn32 = 1'b1; a32 = 32'h1357_9BDF; b32 = 32'h2468_ACE0; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy32, done32, prod32} !== 66'd0) begin
      errors++;
      $display("FAIL midrun_reset busy=%0b done=%0b product=%h required all zero", busy32, done32, prod32);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done32) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midrun_no_done got=%0d pulses required=0", seen);
    end
    $display("midrun reset done_pulses=%0d", seen);
    check_op32("after_reset_12x12", 1'b1, 32'd12, 32'd12);
  endtask

  task automatic test_width8;
    logic [7:0] corner [6];
    logic [15:0] p, exp;
    logic [7:0] x, y;
    bit s;
    int lat;
    corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'hFE};
    for (int k = 0; k < 2 * 36 + 400; k++) begin
      if (k < 72) begin
        s = k[0]; x = corner[(k / 2) % 6]; y = corner[(k / 12) % 6];
      end else begin
        s = 1'($urandom_range(0, 1)); x = 8'($urandom); y = 8'($urandom);
      end
      exp = ref8(s, x, y);
      run8(s, x, y, p, lat);
      checks++;
      if (p !== exp || lat !== 5) begin
        errors++;
        $display("FAIL w8 s=%0b a=%h b=%h got=%h lat=%0d required=%h lat=5", s, x, y, p, lat, exp);
      end
      $display("op8 s=%0b a=%h b=%h product=%h lat=%0d", s, x, y, p, lat);
    end
  endtask

  initial begin
    test_reset;
    test_corners;
    test_random32;
    test_back_to_back;
    test_reset_midrun;
    test_width8;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
